// File: rtl/fir4_pkg.sv
`default_nettype none
// ============================================================================
// Module : fir4_pkg
// Shared width default, FSM state encoding and sample-limit helpers.
// Rev    : 1.0
// ============================================================================
package fir4_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic int sample_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sample_min(input int width);
    return -(1 << (width - 1));
  endfunction

  localparam int SAMPLE_MAX = sample_max(W);
  localparam int SAMPLE_MIN = sample_min(W);

endpackage
`default_nettype wire

// File: rtl/fir4_inv_u_if.sv
`default_nettype none
// ============================================================================
// Module : fir4_inv_u_if
// Sample/result bundle between a fir4 sum source and the inverter.
// Rev    : 1.0
// ============================================================================
interface fir4_inv_u_if
  import fir4_pkg::*;
#(
  parameter int w = W
);
  logic signed [w+1:0] s;
  logic                s_vld;
  logic                clr;
  logic signed [w-1:0] a_out;
  logic                a_vld;
  logic                err;
  logic [1:0]          state_o;

  modport master (
    output s, s_vld, clr,
    input  a_out, a_vld, err, state_o
  );

  modport slave (
    input  s, s_vld, clr,
    output a_out, a_vld, err, state_o
  );
endinterface
`default_nettype wire

// File: rtl/fir4_dly.sv
`default_nettype none
// ============================================================================
// Module : fir4_dly
// Four-deep enabled sample delay line with synchronous clear; all taps visible.
// Rev    : 1.0
// ============================================================================
module fir4_dly #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] d,
  output logic signed [DW-1:0] tap0,
  output logic signed [DW-1:0] tap1,
  output logic signed [DW-1:0] tap2,
  output logic signed [DW-1:0] tap3
);

  logic signed [DW-1:0] r_tap [4];

  // clear outranks enable so a flush never lets a sample slip in
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) r_tap[i] <= '0;
    end else if (en) begin
      r_tap[0] <= d;
      for (int i = 1; i < 4; i++) r_tap[i] <= r_tap[i-1];
    end
  end

  assign tap0 = r_tap[0];
  assign tap1 = r_tap[1];
  assign tap2 = r_tap[2];
  assign tap3 = r_tap[3];

endmodule
`default_nettype wire

// File: rtl/fir4_inv_u.sv
`default_nettype none
// ============================================================================
// Module : fir4_inv_u
// Recovers x[n] from the 4-tap sum s[n] as x[n] = s[n] - s[n-1] + x[n-4].
// Rev    : 1.0
// ============================================================================
module fir4_inv_u
  import fir4_pkg::*;
#(
  parameter int w = W
) (
  input  logic           clk,
  input  logic           reset,
  fir4_inv_u_if.slave    bus
);

  localparam logic signed [w+2:0] c_max = (w+3)'(sample_max(w));
  localparam logic signed [w+2:0] c_min = (w+3)'(sample_min(w));

  state_t              r_state;
  state_t              w_state_nxt;
  logic signed [w+1:0] r_s_prev;
  logic signed [w-1:0] r_a_out;
  logic                r_a_vld;
  logic                r_err;

  logic                w_accept;
  logic                w_clear;
  logic                w_ovf;
  logic signed [w+2:0] w_sum;
  logic signed [w-1:0] w_sat;
  logic signed [w-1:0] w_x1, w_x2, w_x3, w_x4;

  // every operand sign-extended to w+3 so the range check sees the true value
  assign w_sum = {r_s_prev[w+1], r_s_prev} * -1 + {bus.s[w+1], bus.s}
               + {{3{w_x4[w-1]}}, w_x4};

  always_comb begin
    w_ovf = 1'b0;
    w_sat = w_sum[w-1:0];
    if (w_sum > c_max) begin
      w_ovf = 1'b1;
      w_sat = c_max[w-1:0];
    end else if (w_sum < c_min) begin
      w_ovf = 1'b1;
      w_sat = c_min[w-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.clr) w_clear = 1'b1;
        else         w_state_nxt = RUN;
      end
      RUN: begin
        if (bus.clr) begin
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else if (bus.s_vld) begin
          w_accept = 1'b1;
          if (w_ovf) w_state_nxt = FAULT;
        end
      end
      FAULT: begin
        if (bus.clr) begin
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_s_prev <= '0;
      r_a_out  <= '0;
      r_a_vld  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a_vld <= w_accept;
      if (w_clear) begin
        r_s_prev <= '0;
        r_err    <= 1'b0;
      end else if (w_accept) begin
        r_s_prev <= bus.s;
        r_a_out  <= w_sat;
        if (w_ovf) r_err <= 1'b1;
      end
    end
  end

  fir4_dly #(
    .DW (w)
  ) u_dly (
    .clk  (clk),
    .en   (w_accept),
    .clr  (reset | w_clear),
    .d    (w_sat),
    .tap0 (w_x1),
    .tap1 (w_x2),
    .tap2 (w_x3),
    .tap3 (w_x4)
  );

  assign bus.a_out   = r_a_out;
  assign bus.a_vld   = r_a_vld;
  assign bus.err     = r_err;
  assign bus.state_o = r_state;

  // only the oldest tap feeds the recurrence; the rest are exported by fir4_dly
  logic w_unused;
  assign w_unused = ^{w_x1, w_x2, w_x3};

endmodule
`default_nettype wire
